pcie_csr_arb: RTL and testbench

Two-requester arbiter and sequencer in front of the PCIe subsystem CSR slave (DFH at 0x000, scratchpad at 0x008, status at 0x010, unused space up to 0xFF8). Requester 0 is the host MMIO path and requester 1 is the management path. The block grants one requester at a time with round-robin fairness and issues a single outstanding 64-bit read or write to the CSR slave. It returns the completion to the granted requester and optionally converts a hung access into an error completion.

---
 rtl/pcie_csr_arb_pkg.sv | 26 ++
 rtl/pcie_csr_arb_if.sv | 37 +++
 rtl/pcie_csr_arb_rr.sv | 23 ++
 rtl/pcie_csr_arb.sv | 123 ++++++++++++
 tb/tb_pcie_csr_arb.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcie_csr_arb_pkg.sv
// pcie_csr_arb_pkg -- shared types and constants for the PCIe CSR arbiter.
//   state_e        : sequencer states (IDLE, ISSUE, WAIT, RESP)
//   NUM_REQ        : number of requesters (0 = host MMIO, 1 = management)
//   PCIE_*         : CSR slave byte offsets, mainly for test stimulus
package pcie_csr_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [11:0] PCIE_DFH           = 12'h000;
  localparam logic [11:0] PCIE_SCRATCHPAD    = 12'h008;
  localparam logic [11:0] PCIE_STAT          = 12'h010;
  localparam logic [11:0] PCIE_UNUSED_OFFSET = 12'hFF8;

  // 64-bit accesses must be 8-byte aligned
  function automatic logic is_misaligned(input logic [2:0] addr_lsb);
    return addr_lsb != 3'b000;
  endfunction

endpackage

// File: rtl/pcie_csr_arb_if.sv
// pcie_csr_arb_if -- requester and CSR-slave signals of the arbiter.
//   req_* / rsp_* : per-requester request handshake and completion
//   csr_*         : single-outstanding access port to the CSR slave
//   modport slave : arbiter view;  modport master : requesters + CSR slave view
interface pcie_csr_arb_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64
);
  import pcie_csr_arb_pkg::*;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [DATA_W-1:0]              rsp_data;
  logic                           rsp_err;
  logic                           csr_req;
  logic                           csr_write;
  logic [ADDR_W-1:0]              csr_addr;
  logic [DATA_W-1:0]              csr_wdata;
  logic                           csr_ack;
  logic [DATA_W-1:0]              csr_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, csr_ack, csr_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_err,
           csr_req, csr_write, csr_addr, csr_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, csr_ack, csr_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
           csr_req, csr_write, csr_addr, csr_wdata
  );
endinterface

// File: rtl/pcie_csr_arb_rr.sv
// pcie_csr_arb_rr -- combinational 2-way round-robin picker.
//   req_valid  in  per-requester valid
//   last_grant in  index of the most recently granted requester
//   grant      out one-hot grant
//   grant_vld  out at least one requester valid
module pcie_csr_arb_rr
  import pcie_csr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_vld
);

  // a lone requester wins outright; on a tie the one not served last wins
  always_comb begin
    grant = req_valid;
    if (&req_valid) grant = last_grant ? 2'b01 : 2'b10;
  end

  assign grant_vld = |req_valid;

endmodule

// File: rtl/pcie_csr_arb.sv
// pcie_csr_arb -- two-requester round-robin arbiter/sequencer in front of
// the PCIe CSR slave. One outstanding 64-bit access at a time.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pcie_csr_arb_if.slave (request, completion and CSR ports)
// Optional: define PCIE_CSR_ARB_TIMEOUT_EN to turn a WAIT lasting
// TIMEOUT_CYC cycles into an error completion; otherwise WAIT is unbounded.
module pcie_csr_arb
  import pcie_csr_arb_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  pcie_csr_arb_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_WAIT  = WAIT;
  localparam logic [1:0] ST_RESP  = RESP;

  logic [1:0]         state, state_nxt;
  logic               last_grant;
  logic [NUM_REQ-1:0] gnt, gnt_q;
  logic               gnt_vld, gnt_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic               misaligned, accept, to_hit;
  logic               csr_write_q;
  logic [ADDR_W-1:0]  csr_addr_q;
  logic [DATA_W-1:0]  csr_wdata_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               rsp_err_q;

  pcie_csr_arb_rr u_rr (
    .req_valid  (bus.req_valid),
    .last_grant (last_grant),
    .grant      (gnt),
    .grant_vld  (gnt_vld)
  );

  assign gnt_idx    = gnt[1];
  assign sel_addr   = bus.req_addr[gnt_idx];
  assign misaligned = is_misaligned(sel_addr[2:0]);
  assign accept     = (state == ST_IDLE) && gnt_vld;

  assign bus.req_ready = accept ? gnt : '0;
  assign bus.rsp_valid = (state == ST_RESP) ? gnt_q : '0;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.csr_req   = (state == ST_ISSUE);
  assign bus.csr_write = csr_write_q;
  assign bus.csr_addr  = csr_addr_q;
  assign bus.csr_wdata = csr_wdata_q;

`ifdef PCIE_CSR_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] to_cnt;

  // cleared while in ISSUE so it starts at 0 on the first WAIT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               to_cnt <= '0;
    else if (state == ST_ISSUE)               to_cnt <= '0;
    else if (state == ST_WAIT && !bus.csr_ack) to_cnt <= to_cnt + CNT_W'(1);
  end

  // an ack on the terminal count still wins
  assign to_hit = (state == ST_WAIT) && !bus.csr_ack &&
                  (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYC;
  assign to_hit         = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (gnt_vld) state_nxt = misaligned ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (bus.csr_ack || to_hit) state_nxt = ST_RESP;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_grant  <= 1'b1;
      gnt_q       <= '0;
      csr_write_q <= 1'b0;
      csr_addr_q  <= '0;
      csr_wdata_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        gnt_q       <= gnt;
        last_grant  <= gnt_idx;
        csr_write_q <= bus.req_write[gnt_idx];
        csr_addr_q  <= sel_addr;
        csr_wdata_q <= bus.req_wdata[gnt_idx];
        // misaligned requests complete straight from here, no slave access
        if (misaligned) begin
          rsp_data_q <= '1;
          rsp_err_q  <= 1'b1;
        end
      end
      if (state == ST_WAIT) begin
        if (bus.csr_ack) begin
          rsp_data_q <= csr_write_q ? '0 : bus.csr_rdata;
          rsp_err_q  <= 1'b0;
        end else if (to_hit) begin
          rsp_data_q <= '1;
          rsp_err_q  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pcie_csr_arb.sv
`timescale 1ns/1ps
module tb_pcie_csr_arb;
  import pcie_csr_arb_pkg::*;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 64;
  localparam int TO_CYC = 256;

  localparam logic [63:0] DFH_VAL  = 64'h1000_0000_0000_0A55;
  localparam logic [63:0] STAT_VAL = 64'h0000_0000_0000_00C3;
  localparam logic [63:0] INJ_VAL  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] WR_JUNK  = 64'hFFFF_0000_BAD0_BAD0;
  localparam logic [63:0] ONES     = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] WR_VAL   = 64'hDEADBEEF_12345678;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pcie_csr_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  pcie_csr_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { int cyc; logic [1:0] vec; } acc_t;
  typedef struct { int cyc; logic [1:0] vec; logic [63:0] data; logic err; } rsp_t;
  typedef struct { int cyc; logic wr; logic [11:0] addr; logic [63:0] wdata; } creq_t;
  typedef struct { int id; logic [63:0] data; logic err; } exp_t;

  acc_t  acc_log[$];
  rsp_t  rsp_log[$];
  creq_t creq_log[$];
  exp_t  exp_q[$];

  int cyc;
  int checks, errors;
  int rsp_rd;

  // slave model controls
  bit          slave_en = 1'b1;
  int          ack_dly  = 1;
  int          inj_cnt  = 0;
  logic [63:0] scratch  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // passive monitor: log every accept, completion and slave strobe
  always @(negedge clk) begin
    if (bus.req_ready != 2'b00) acc_log.push_back('{cyc, bus.req_ready});
    if (bus.rsp_valid != 2'b00) rsp_log.push_back('{cyc, bus.rsp_valid, bus.rsp_data, bus.rsp_err});
    if (bus.csr_req) creq_log.push_back('{cyc, bus.csr_write, bus.csr_addr, bus.csr_wdata});
  end

  function automatic logic [63:0] rd_model(input logic [11:0] a);
    case (a)
      PCIE_DFH:        return DFH_VAL;
      PCIE_SCRATCHPAD: return scratch;
      PCIE_STAT:       return STAT_VAL;
      default:         return 64'h0;
    endcase
  endfunction

  // CSR slave: acks ack_dly cycles after csr_req; inj_cnt bumps force a stray ack
  initial begin : slave
    int cd = 0;
    int inj_seen = 0;
    logic wr_l = 1'b0;
    logic [11:0] addr_l = '0;
    bus.csr_ack   = 1'b0;
    bus.csr_rdata = '0;
    forever begin
      @(negedge clk);
      bus.csr_ack = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.csr_ack   = 1'b1;
          bus.csr_rdata = wr_l ? WR_JUNK : rd_model(addr_l);
        end
      end else if (inj_seen != inj_cnt) begin
        inj_seen      = inj_cnt;
        bus.csr_ack   = 1'b1;
        bus.csr_rdata = INJ_VAL;
      end
      if (bus.csr_req && slave_en) begin
        wr_l   = bus.csr_write;
        addr_l = bus.csr_addr;
        if (wr_l && addr_l == PCIE_SCRATCHPAD) scratch = bus.csr_wdata;
        cd = ack_dly;
      end
    end
  end

  task automatic issue(input int i, input logic wr, input logic [11:0] addr,
                       input logic [63:0] wd, output int acc_cyc, output bit ok);
    @(posedge clk); #1;
    bus.req_write[i] = wr;
    bus.req_addr[i]  = addr;
    bus.req_wdata[i] = wd;
    bus.req_valid[i] = 1'b1;
    ok = 1'b0;
    acc_cyc = -1000;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk);
      if (bus.req_ready[i]) begin ok = 1'b1; acc_cyc = cyc; end
    end
    @(posedge clk); #1;
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic get_rsp(input int bound, output rsp_t r, output bit ok);
    ok = 1'b0;
    r  = '{-1000, 2'b00, 64'h0, 1'b0};
    for (int n = 0; n < bound && rsp_log.size() <= rsp_rd; n++) begin
      @(negedge clk); #1;
    end
    if (rsp_log.size() > rsp_rd) begin
      r = rsp_log[rsp_rd];
      rsp_rd++;
      ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.csr_req, bus.csr_write} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b rsp_valid=%b err=%b csr_req=%b csr_write=%b, want all 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.csr_req, bus.csr_write);
    end
    checks++;
    if (bus.rsp_data !== 64'h0) begin
      errors++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data);
    end
    checks++;
    if (bus.csr_addr !== 12'h0 || bus.csr_wdata !== 64'h0) begin
      errors++; $display("FAIL reset_csr: got addr=%h wdata=%h want 0", bus.csr_addr, bus.csr_wdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    rsp_t r; exp_t e; creq_t c; int a; bit ok, rok; int c0;
    ack_dly = 2;
    c0 = creq_log.size();
    exp_q.push_back('{0, 64'h0, 1'b0});
    issue(0, 1'b1, PCIE_SCRATCHPAD, WR_VAL, a, ok);
    get_rsp(40, r, rok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || !rok || {r.vec, r.err, r.data} !== {2'(1 << e.id), e.err, e.data}) begin
      errors++;
      $display("FAIL wr_rsp: got vec=%b err=%b data=%h, want vec=%b err=%b data=%h",
               r.vec, r.err, r.data, 2'(1 << e.id), e.err, e.data);
    end
    checks++;
    if (r.cyc - a != 4) begin
      errors++; $display("FAIL wr_latency: got %0d cycles want 4", r.cyc - a);
    end
    c = (creq_log.size() > c0) ? creq_log[c0] : '{-1000, 1'b0, 12'h0, 64'h0};
    checks++;
    if (creq_log.size() != c0 + 1 || c.cyc != a + 1 || {c.wr, c.addr, c.wdata} !== {1'b1, PCIE_SCRATCHPAD, WR_VAL}) begin
      errors++;
      $display("FAIL wr_csr_req: got n=%0d dt=%0d wr=%b addr=%h wdata=%h, want n=1 dt=1 wr=1 addr=008 wdata=%h",
               creq_log.size() - c0, c.cyc - a, c.wr, c.addr, c.wdata, WR_VAL);
    end
    exp_q.push_back('{1, WR_VAL, 1'b0});
    issue(1, 1'b0, PCIE_SCRATCHPAD, 64'h0, a, ok);
    get_rsp(40, r, rok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || !rok || {r.vec, r.err, r.data} !== {2'(1 << e.id), e.err, e.data}) begin
      errors++;
      $display("FAIL rd_rsp: got vec=%b err=%b data=%h, want vec=%b err=%b data=%h",
               r.vec, r.err, r.data, 2'(1 << e.id), e.err, e.data);
    end
  endtask

  task automatic test_round_robin();
    rsp_t r; exp_t e; int a0, a1; bit ok0, ok1, rok; int base;
    ack_dly = 1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    base = acc_log.size();
    for (int round = 0; round < 2; round++) begin
      exp_q.push_back('{0, DFH_VAL, 1'b0});
      exp_q.push_back('{1, STAT_VAL, 1'b0});
      fork
        issue(0, 1'b0, PCIE_DFH, 64'h0, a0, ok0);
        issue(1, 1'b0, PCIE_STAT, 64'h0, a1, ok1);
      join
      for (int k = 0; k < 2; k++) begin
        get_rsp(40, r, rok);
        e = exp_q.pop_front();
        checks++;
        if (!ok0 || !ok1 || !rok || {r.vec, r.err, r.data} !== {2'(1 << e.id), e.err, e.data}) begin
          errors++;
          $display("FAIL rr_rsp r%0d k%0d: got vec=%b err=%b data=%h, want vec=%b err=%b data=%h",
                   round, k, r.vec, r.err, r.data, 2'(1 << e.id), e.err, e.data);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      logic [1:0] v;
      v = (acc_log.size() > base + k) ? acc_log[base + k].vec : 2'b00;
      checks++;
      if (v !== 2'(1 << (k % 2))) begin
        errors++; $display("FAIL rr_order %0d: got grant %b want %b", k, v, 2'(1 << (k % 2)));
      end
    end
  endtask

  task automatic test_misaligned();
    rsp_t r; exp_t e; int a; bit ok, rok; int c0;
    c0 = creq_log.size();
    exp_q.push_back('{1, ONES, 1'b1});
    issue(1, 1'b0, 12'h009, 64'h0, a, ok);
    get_rsp(20, r, rok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || !rok || {r.vec, r.err, r.data} !== {2'(1 << e.id), e.err, e.data}) begin
      errors++;
      $display("FAIL misalign_rsp: got vec=%b err=%b data=%h, want vec=%b err=%b data=%h",
               r.vec, r.err, r.data, 2'(1 << e.id), e.err, e.data);
    end
    checks++;
    if (r.cyc - a != 1) begin
      errors++; $display("FAIL misalign_latency: got %0d want 1", r.cyc - a);
    end
    checks++;
    if (creq_log.size() != c0) begin
      errors++; $display("FAIL misalign_no_access: got %0d csr_req want 0", creq_log.size() - c0);
    end
  endtask

  task automatic test_timeout();
    rsp_t r; exp_t e; int a; bit ok, rok; int c0, ccyc;
    slave_en = 1'b0;
    c0 = creq_log.size();
`ifdef PCIE_CSR_ARB_TIMEOUT_EN
    exp_q.push_back('{0, ONES, 1'b1});
    issue(0, 1'b0, PCIE_UNUSED_OFFSET, 64'h0, a, ok);
    get_rsp(TO_CYC + 50, r, rok);
    e = exp_q.pop_front();
    ccyc = (creq_log.size() > c0) ? creq_log[c0].cyc : -1000;
    checks++;
    if (!ok || !rok || {r.vec, r.err, r.data} !== {2'(1 << e.id), e.err, e.data}) begin
      errors++;
      $display("FAIL timeout_rsp: got vec=%b err=%b data=%h, want vec=%b err=%b data=%h",
               r.vec, r.err, r.data, 2'(1 << e.id), e.err, e.data);
    end
    checks++;
    if (r.cyc - ccyc != TO_CYC + 1) begin
      errors++; $display("FAIL timeout_latency: got %0d want %0d", r.cyc - ccyc, TO_CYC + 1);
    end
    repeat (10) @(negedge clk);
    inj_cnt++;
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (rsp_log.size() != rsp_rd) begin
      errors++; $display("FAIL late_ack_ignored: got %0d extra completions want 0", rsp_log.size() - rsp_rd);
    end
`else
    exp_q.push_back('{0, INJ_VAL, 1'b0});
    issue(0, 1'b0, PCIE_UNUSED_OFFSET, 64'h0, a, ok);
    repeat (TO_CYC + 40) @(negedge clk);
    #1;
    checks++;
    if (!ok || rsp_log.size() != rsp_rd || creq_log.size() != c0 + 1) begin
      errors++;
      $display("FAIL wait_forever: got ok=%b completions=%0d csr_req=%0d, want ok=1 0 completions 1 csr_req",
               ok, rsp_log.size() - rsp_rd, creq_log.size() - c0);
    end
    checks++;
    if (bus.csr_addr !== PCIE_UNUSED_OFFSET || bus.csr_write !== 1'b0) begin
      errors++; $display("FAIL wait_stable: got addr=%h wr=%b want addr=ff8 wr=0", bus.csr_addr, bus.csr_write);
    end
    inj_cnt++;
    get_rsp(10, r, rok);
    e = exp_q.pop_front();
    ccyc = 0;
    checks++;
    if (!rok || {r.vec, r.err, r.data} !== {2'(1 << e.id), e.err, e.data}) begin
      errors++;
      $display("FAIL wait_ack_rsp: got vec=%b err=%b data=%h, want vec=%b err=%b data=%h",
               r.vec, r.err, r.data, 2'(1 << e.id), e.err, e.data);
    end
`endif
    slave_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    rsp_t r; exp_t e; int a, a0, a1; bit ok, ok0, ok1, rok; int c0, base;
    ack_dly = 8;
    c0 = creq_log.size();
    issue(0, 1'b0, PCIE_DFH, 64'h0, a, ok);
    for (int n = 0; n < 20 && creq_log.size() == c0; n++) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.csr_req, bus.csr_write} !== 7'b0 ||
        bus.rsp_data !== 64'h0 || bus.csr_addr !== 12'h0 || bus.csr_wdata !== 64'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got rsp_valid=%b err=%b data=%h csr_req=%b addr=%h, want all 0",
               bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.csr_req, bus.csr_addr);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    checks++;
    if (!ok || rsp_log.size() != rsp_rd || bus.csr_addr !== 12'h0 || bus.rsp_data !== 64'h0) begin
      errors++;
      $display("FAIL mid_reset_discard: got ok=%b completions=%0d addr=%h data=%h, want ok=1 0 completions zeros",
               ok, rsp_log.size() - rsp_rd, bus.csr_addr, bus.rsp_data);
    end
    ack_dly = 1;
    base = acc_log.size();
    exp_q.push_back('{0, DFH_VAL, 1'b0});
    exp_q.push_back('{1, STAT_VAL, 1'b0});
    fork
      issue(0, 1'b0, PCIE_DFH, 64'h0, a0, ok0);
      issue(1, 1'b0, PCIE_STAT, 64'h0, a1, ok1);
    join
    checks++;
    if (!ok0 || !ok1 || acc_log.size() <= base || acc_log[base].vec !== 2'b01) begin
      errors++; $display("FAIL post_reset_tie: got first grant %b want 01",
                         (acc_log.size() > base) ? acc_log[base].vec : 2'b00);
    end
    for (int k = 0; k < 2; k++) begin
      get_rsp(40, r, rok);
      e = exp_q.pop_front();
      checks++;
      if (!rok || {r.vec, r.err, r.data} !== {2'(1 << e.id), e.err, e.data}) begin
        errors++;
        $display("FAIL post_reset_rsp %0d: got vec=%b err=%b data=%h, want vec=%b err=%b data=%h",
                 k, r.vec, r.err, r.data, 2'(1 << e.id), e.err, e.data);
      end
    end
  endtask

  task automatic test_back_to_back();
    rsp_t r; exp_t e; acc_t ac; bit rok; int base, prev_rsp;
    int a0[4], a1[4];
    bit ok0[4], ok1[4];
    ack_dly = 1;
    base = acc_log.size();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back('{0, 64'h0, 1'b0});
      exp_q.push_back('{1, 64'hA5A5_0000_0000_0000 + 64'(k), 1'b0});
    end
    fork
      begin
        for (int k = 0; k < 4; k++)
          issue(0, 1'b1, PCIE_SCRATCHPAD, 64'hA5A5_0000_0000_0000 + 64'(k), a0[k], ok0[k]);
      end
      begin
        for (int k = 0; k < 4; k++)
          issue(1, 1'b0, PCIE_SCRATCHPAD, 64'h0, a1[k], ok1[k]);
      end
    join
    prev_rsp = 0;
    for (int k = 0; k < 8; k++) begin
      get_rsp(40, r, rok);
      e  = exp_q.pop_front();
      ac = (acc_log.size() > base + k) ? acc_log[base + k] : '{-1000, 2'b00};
      checks++;
      if (!rok || {r.vec, r.err, r.data} !== {2'(1 << e.id), e.err, e.data}) begin
        errors++;
        $display("FAIL b2b_rsp %0d: got vec=%b err=%b data=%h, want vec=%b err=%b data=%h",
                 k, r.vec, r.err, r.data, 2'(1 << e.id), e.err, e.data);
      end
      checks++;
      if (ac.vec !== 2'(1 << (k % 2)) || r.cyc - ac.cyc != 3) begin
        errors++;
        $display("FAIL b2b_timing %0d: got grant=%b latency=%0d, want grant=%b latency=3",
                 k, ac.vec, r.cyc - ac.cyc, 2'(1 << (k % 2)));
      end
      if (k > 0) begin
        checks++;
        if (ac.cyc - prev_rsp != 1) begin
          errors++; $display("FAIL b2b_gap %0d: got %0d want 1", k, ac.cyc - prev_rsp);
        end
      end
      prev_rsp = r.cyc;
    end
    checks++;
    if (!(ok0[3] && ok1[3])) begin
      errors++; $display("FAIL b2b_accept: got ok0=%b ok1=%b want 1 1", ok0[3], ok1[3]);
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    checks = 0;
    errors = 0;
    rsp_rd = 0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
